// File: rtl/btn_pulse_gen.sv
// Push-button conditioner: synchronizer, debounce FSM, single-cycle press/release pulses and a press counter.
// Optional auto-repeat of press pulses while held: define BTN_AUTO_REPEAT_EN.
`timescale 1ns/1ps

module btn_pulse_gen #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DB_LIMIT    = 1000000,
   parameter int unsigned CNT_W       = 20
`ifdef BTN_AUTO_REPEAT_EN
   ,
   parameter int unsigned REPEAT_DELAY  = 50000000,
   parameter int unsigned REPEAT_PERIOD = 10000000
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_in,
   output logic        btn_level,
   output logic        press_pulse,
   output logic        release_pulse,
   output logic [15:0] press_cnt
);

   localparam int unsigned PCNT_W = 16;
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_LIMIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } state_t;

   logic [SYNC_STAGES-1:0] sync;
   logic                   btn_s;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic                level_nxt;
   logic                press_nxt;
   logic                release_nxt;
   logic [PCNT_W-1:0]   press_cnt_nxt;

`ifdef BTN_AUTO_REPEAT_EN
   logic [31:0] hold_tmr, hold_tmr_nxt;
   logic        repeating, repeating_nxt;
   logic [31:0] rpt_last;

   // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
   assign rpt_last = repeating ? 32'(REPEAT_PERIOD - 1) : 32'(REPEAT_DELAY - 1);
`endif

   // Metastability synchronizer; only the last stage feeds the FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], btn_in};
      end
   end

   assign btn_s = sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         press_cnt     <= '0;
`ifdef BTN_AUTO_REPEAT_EN
         hold_tmr      <= '0;
         repeating     <= 1'b0;
`endif
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         btn_level     <= level_nxt;
         press_pulse   <= press_nxt;
         release_pulse <= release_nxt;
         press_cnt     <= press_cnt_nxt;
`ifdef BTN_AUTO_REPEAT_EN
         hold_tmr      <= hold_tmr_nxt;
         repeating     <= repeating_nxt;
`endif
      end
   end

   // Debounce decisions: a level change is accepted after DB_LIMIT stable samples.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      level_nxt     = btn_level;
      press_nxt     = 1'b0;
      release_nxt   = 1'b0;
      press_cnt_nxt = press_cnt;
`ifdef BTN_AUTO_REPEAT_EN
      hold_tmr_nxt  = hold_tmr;
      repeating_nxt = repeating;
`endif
      case (state)
         IDLE: begin
            if (btn_s) begin
               state_nxt = PRESS_WAIT;
               cnt_nxt   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!btn_s) begin
               state_nxt = IDLE;
            end else if (cnt == DB_LAST) begin
               state_nxt     = HELD;
               level_nxt     = 1'b1;
               press_nxt     = 1'b1;
               press_cnt_nxt = press_cnt + PCNT_W'(1);
`ifdef BTN_AUTO_REPEAT_EN
               hold_tmr_nxt  = '0;
               repeating_nxt = 1'b0;
`endif
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         HELD: begin
            if (!btn_s) begin
               state_nxt = RELEASE_WAIT;
               cnt_nxt   = '0;
            end
`ifdef BTN_AUTO_REPEAT_EN
            else if (hold_tmr == rpt_last) begin
               press_nxt     = 1'b1;
               press_cnt_nxt = press_cnt + PCNT_W'(1);
               hold_tmr_nxt  = '0;
               repeating_nxt = 1'b1;
            end else begin
               hold_tmr_nxt = hold_tmr + 32'd1;
            end
`endif
         end
         RELEASE_WAIT: begin
            if (btn_s) begin
               state_nxt = HELD;
            end else if (cnt == DB_LAST) begin
               state_nxt   = IDLE;
               level_nxt   = 1'b0;
               release_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Directed bench for btn_pulse_gen with SYNC_STAGES=2, DB_LIMIT=4: vector table plus multi-cycle corner sequences.
`timescale 1ns/1ps

module tb_btn_pulse_gen;

   logic        clk;
   logic        rst;
   logic        btn_in;
   logic        btn_level;
   logic        press_pulse;
   logic        release_pulse;
   logic [15:0] press_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst;
      logic        btn;
      logic        lvl;
      logic        prs;
      logic        rel;
      logic [15:0] pcnt;
   } vec_t;

   vec_t vecs[$];

   btn_pulse_gen #(
      .SYNC_STAGES(2),
      .DB_LIMIT   (4),
      .CNT_W      (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_in       (btn_in),
      .btn_level    (btn_level),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .press_cnt    (press_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic b, input logic l,
                               input logic p, input logic rl, input logic [15:0] c);
      vec_t v;
      v.rst  = r;
      v.btn  = b;
      v.lvl  = l;
      v.prs  = p;
      v.rel  = rl;
      v.pcnt = c;
      return v;
   endfunction

   // Apply inputs ahead of the edge, then sample 1 ns after it.
   task automatic step(input logic r, input logic b);
      rst    = r;
      btn_in = b;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
      end
   endtask

   initial begin
      rst    = 1'b1;
      btn_in = 1'b0;

      // Reset: two cycles.
      for (int i = 0; i < 2; i++) vecs.push_back(mk(1, 0, 0, 0, 0, 16'd0));
      // Clean press: pulse after the 7th edge.
      for (int i = 0; i < 6; i++) vecs.push_back(mk(0, 1, 0, 0, 0, 16'd0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 16'd1));
      for (int i = 0; i < 2; i++) vecs.push_back(mk(0, 1, 1, 0, 0, 16'd1));
      // Clean release: symmetric latency.
      for (int i = 0; i < 6; i++) vecs.push_back(mk(0, 0, 1, 0, 0, 16'd1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 16'd1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 16'd1));
      // Bounce 1,1,0,1,1,0 then 0s: never accepted.
      vecs.push_back(mk(0, 1, 0, 0, 0, 16'd1));
      vecs.push_back(mk(0, 1, 0, 0, 0, 16'd1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 16'd1));
      vecs.push_back(mk(0, 1, 0, 0, 0, 16'd1));
      vecs.push_back(mk(0, 1, 0, 0, 0, 16'd1));
      for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 16'd1));

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].btn);
         chk("vec_level",   i, 16'(btn_level),     16'(vecs[i].lvl));
         chk("vec_press",   i, 16'(press_pulse),   16'(vecs[i].prs));
         chk("vec_release", i, 16'(release_pulse), 16'(vecs[i].rel));
         chk("vec_cnt",     i, press_cnt,          vecs[i].pcnt);
         chk("vec_excl",    i, 16'(press_pulse & release_pulse), 16'd0);
      end

      // Press again to reach HELD.
      for (int k = 1; k <= 7; k++) begin
         step(0, 1);
         chk("press2_pulse", k, 16'(press_pulse), 16'(k == 7));
      end
      chk("press2_cnt", 0, press_cnt, 16'd2);
      step(0, 1);

      // Release with a one-cycle bounce: 0,0,1 then 0 held.
      for (int k = 1; k <= 12; k++) begin
         step(0, (k == 3));
         chk("relb_release", k, 16'(release_pulse), 16'(k == 10));
         chk("relb_press",   k, 16'(press_pulse),   16'd0);
         chk("relb_level",   k, 16'(btn_level),     16'(k < 10));
      end
      chk("relb_cnt", 0, press_cnt, 16'd2);

      // Reset in PRESS_WAIT with cnt=2, then full recount.
      for (int k = 1; k <= 5; k++) begin
         step(0, 1);
         chk("rstmid_pre_press", k, 16'(press_pulse), 16'd0);
      end
      step(1, 1);
      chk("rstmid_press", 0, 16'(press_pulse), 16'd0);
      chk("rstmid_level", 0, 16'(btn_level),   16'd0);
      chk("rstmid_cnt",   0, press_cnt,        16'd0);
      for (int k = 1; k <= 7; k++) begin
         step(0, 1);
         chk("rstmid_recount", k, 16'(press_pulse), 16'(k == 7));
      end
      chk("rstmid_cnt_after",   0, press_cnt,      16'd1);
      chk("rstmid_level_after", 0, 16'(btn_level), 16'd1);

      // Counter wrap: preload 0xFFFF, then one accepted press.
      for (int k = 1; k <= 8; k++) step(0, 0);
      chk("wrap_idle_level", 0, 16'(btn_level), 16'd0);
      force dut.press_cnt = 16'hFFFF;
      step(0, 0);
      step(0, 0);
      release dut.press_cnt;
      step(0, 0);
      chk("wrap_preload", 0, press_cnt, 16'hFFFF);
      for (int k = 1; k <= 7; k++) begin
         step(0, 1);
         chk("wrap_press", k, 16'(press_pulse), 16'(k == 7));
         chk("wrap_cnt",   k, press_cnt,        (k == 7) ? 16'h0000 : 16'hFFFF);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
